// File: rtl/pipe_stage_skid_if.sv
// Handshake/payload bundle for pipe_stage_skid: upstream valid/ready + payload,
// downstream valid/ready + payload.
// Ports: master = producer/consumer side driving payload in and ready out;
//        slave  = the pipeline stage itself.
interface pipe_stage_skid_if #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32,
  parameter int VAL_W = 32
);
  // upstream side
  logic             in_valid;
  logic             in_ready;
  logic [PC_W-1:0]  pc;
  logic [INS_W-1:0] instruct;
  logic [VAL_W-1:0] valA;
  logic [VAL_W-1:0] valB;
  // downstream side
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pcOut;
  logic [INS_W-1:0] instructOut;
  logic [VAL_W-1:0] valAOut;
  logic [VAL_W-1:0] valBOut;

  modport master (
    output in_valid, pc, instruct, valA, valB, out_ready,
    input  in_ready, out_valid, pcOut, instructOut, valAOut, valBOut
  );

  modport slave (
    input  in_valid, pc, instruct, valA, valB, out_ready,
    output in_ready, out_valid, pcOut, instructOut, valAOut, valBOut
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register (main + skid) with flush and a
// saturating downstream-stall counter. Latency 1 cycle, one payload/cycle.
// Backpressure: in_ready comes from the state register only (low when both
// entries are full), so there is no combinational out_ready -> in_ready path.
// Ports: clock, res (sync, active-high), flush; bus (slave modport) carries
//        both handshakes and payloads; occ = entries held; stallCnt = stalls.
module pipe_stage_skid #(
  parameter int               PC_W  = 32,
  parameter int               INS_W = 32,
  parameter int               VAL_W = 32,
  parameter logic [INS_W-1:0] NOP   = '0,
  parameter int               CNT_W = 16
) (
  input  logic                clock,
  input  logic                res,
  input  logic                flush,
  pipe_stage_skid_if.slave    bus,
  output logic [1:0]          occ,
  output logic [CNT_W-1:0]    stallCnt
);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] ins;
    logic [VAL_W-1:0] va;
    logic [VAL_W-1:0] vb;
  } payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  payload_t         main_q, main_d;
  payload_t         skid_q, skid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  payload_t in_pay;
  logic     in_ready_int;
  logic     out_valid_int;
  logic     accept;
  logic     fire;

  assign in_pay        = {bus.pc, bus.instruct, bus.valA, bus.valB};
  assign in_ready_int  = (state_q != ST_TWO);
  assign out_valid_int = (state_q != ST_EMPTY);
  assign accept        = bus.in_valid && in_ready_int;
  assign fire          = out_valid_int && bus.out_ready;

  // Next-state and payload movement.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          main_d  = in_pay;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_d = in_pay;
        end else if (accept) begin
          // main is stalled: park the newcomer in the skid entry
          state_d = ST_TWO;
          skid_d  = in_pay;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (fire) begin
          state_d = ST_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush drops everything held and any same-cycle input; pc/valA/valB
    // keep their last value so only the instruction becomes a bubble.
    if (flush) begin
      state_d    = ST_EMPTY;
      main_d     = main_q;
      main_d.ins = NOP;
      skid_d     = skid_q;
    end
  end

  // Stall counter ignores flush by design: it measures downstream backpressure.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_int && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    occ = 2'd0;
    case (state_q)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (res) begin
      state_q     <= ST_EMPTY;
      main_q      <= '{pc: '0, ins: NOP, va: '0, vb: '0};
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_int;
  assign bus.out_valid   = out_valid_int;
  assign bus.pcOut       = main_q.pc;
  assign bus.instructOut = out_valid_int ? main_q.ins : NOP;
  assign bus.valAOut     = main_q.va;
  assign bus.valBOut     = main_q.vb;
  assign stallCnt        = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model every cycle.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pipe_stage_skid;

  localparam int          PC_W    = 32;
  localparam int          INS_W   = 32;
  localparam int          VAL_W   = 32;
  localparam int          CNT_W   = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [31:0] va;
    logic [31:0] vb;
  } pay_t;

  logic             clock = 1'b0;
  logic             res;
  logic             flush;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stallCnt;

  pipe_stage_skid_if #(.PC_W(PC_W), .INS_W(INS_W), .VAL_W(VAL_W)) bus ();

  pipe_stage_skid #(
    .PC_W(PC_W), .INS_W(INS_W), .VAL_W(VAL_W), .NOP(NOP), .CNT_W(CNT_W)
  ) dut (
    .clock   (clock),
    .res     (res),
    .flush   (flush),
    .bus     (bus),
    .occ     (occ),
    .stallCnt(stallCnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: FIFO contents, last shown payload, stall count
  pay_t        mq[$];
  logic [31:0] sh_pc = '0;
  logic [31:0] sh_va = '0;
  logic [31:0] sh_vb = '0;
  int          exp_cnt = 0;
  int          vld_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic pay_t mk(input logic [31:0] pc, input logic [31:0] ins);
    pay_t p;
    p.pc  = pc;
    p.ins = ins;
    p.va  = pc ^ 32'hA5A5_0000;
    p.vb  = ins ^ 32'h0000_5A5A;
    return p;
  endfunction

  function automatic pay_t rnd_pay();
    pay_t p;
    p.pc  = $urandom;
    p.ins = $urandom;
    p.va  = $urandom;
    p.vb  = $urandom;
    return p;
  endfunction

  // One clock cycle: drive, let the edge happen, advance the model, compare.
  task automatic step(input logic r, input logic f, input logic iv, input logic ordy, input pay_t p);
    bit acc;
    bit fir;
    bit any;
    res           = r;
    flush         = f;
    bus.in_valid  = iv;
    bus.pc        = p.pc;
    bus.instruct  = p.ins;
    bus.valA      = p.va;
    bus.valB      = p.vb;
    bus.out_ready = ordy;
    acc = iv && (mq.size() < 2);
    fir = (mq.size() > 0) && ordy;
    any = (mq.size() > 0);
    @(posedge clock);
    if (r) begin
      mq.delete();
      sh_pc   = '0;
      sh_va   = '0;
      sh_vb   = '0;
      exp_cnt = 0;
    end else begin
      if (any && !ordy && exp_cnt < CNT_MAX) exp_cnt++;
      if (f) begin
        mq.delete();
      end else begin
        if (fir) void'(mq.pop_front());
        if (acc) mq.push_back(p);
      end
      if (mq.size() > 0) begin
        sh_pc = mq[0].pc;
        sh_va = mq[0].va;
        sh_vb = mq[0].vb;
      end
    end
    @(negedge clock);
    vld_seen += int'(bus.out_valid);
    check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check_eq("in_ready",  64'(bus.in_ready),  64'(mq.size() < 2));
    check_eq("occ",       64'(occ),           64'(mq.size()));
    check_eq("pcOut",     64'(bus.pcOut),     64'(sh_pc));
    check_eq("valAOut",   64'(bus.valAOut),   64'(sh_va));
    check_eq("valBOut",   64'(bus.valBOut),   64'(sh_vb));
    check_eq("instructOut", 64'(bus.instructOut),
             (mq.size() > 0) ? 64'(mq[0].ins) : 64'(NOP));
    check_eq("stallCnt",  64'(stallCnt),      64'(exp_cnt));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, ordy, mk(32'h0, 32'h0));
  endtask

  initial begin
    int exp_stall[5];
    exp_stall = '{1, 2, 3, 3, 3};
    res = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.pc = '0;
    bus.instruct = '0;
    bus.valA = '0;
    bus.valB = '0;
    bus.out_ready = 1'b0;

    // reset
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0));
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0));
    check_eq("rst_instructOut", 64'(bus.instructOut), 64'(NOP));

    // single payload, one-cycle latency
    step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h100, 32'h1234));
    check_eq("lat_pcOut", 64'(bus.pcOut), 64'h100);
    check_eq("lat_ins",   64'(bus.instructOut), 64'h1234);
    check_eq("lat_occ",   64'(occ), 64'd1);
    idle(1'b1);

    // fill both entries under backpressure, then drain in order
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h10, 32'hAAAA));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h14, 32'hBBBB));
    check_eq("two_occ",   64'(occ), 64'd2);
    check_eq("two_rdy",   64'(bus.in_ready), 64'd0);
    check_eq("two_pcOut", 64'(bus.pcOut), 64'h10);
    idle(1'b1);
    check_eq("drain_pc1", 64'(bus.pcOut), 64'h14);
    idle(1'b1);
    check_eq("drain_occ", 64'(occ), 64'd0);

    // streaming 8 payloads back-to-back
    vld_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, mk(32'h200 + 32'(i * 4), 32'(i)));
    idle(1'b1);
    check_eq("stream_vld_cycles", 64'(vld_seen), 64'd8);

    // flush from TWO with a same-cycle input
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h300, 32'h1));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h304, 32'h2));
    step(1'b0, 1'b1, 1'b1, 1'b0, mk(32'h308, 32'h3));
    check_eq("flush_occ", 64'(occ), 64'd0);
    check_eq("flush_ins", 64'(bus.instructOut), 64'(NOP));
    check_eq("flush_rdy", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // stall counter saturation, then reset clears it
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h400, 32'h5));
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check_eq("stall_seq", 64'(stallCnt), 64'(exp_stall[i]));
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h0, 32'h0));
    check_eq("stall_rst", 64'(stallCnt), 64'd0);

    // reset beats flush with both entries occupied
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h500, 32'h7));
    step(1'b0, 1'b0, 1'b1, 1'b0, mk(32'h504, 32'h8));
    step(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h508, 32'h9));
    check_eq("rf_occ",   64'(occ), 64'd0);
    check_eq("rf_vld",   64'(bus.out_valid), 64'd0);
    check_eq("rf_rdy",   64'(bus.in_ready), 64'd1);
    check_eq("rf_pcOut", 64'(bus.pcOut), 64'd0);
    check_eq("rf_ins",   64'(bus.instructOut), 64'(NOP));
    check_eq("rf_cnt",   64'(stallCnt), 64'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rnd_pay());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
